// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmitter.
// Holds the frame FSM state encoding, line levels and parity-type encodings.
// Imported by uart_tx_serializer and uart_tx_top.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit for a frame given the XOR-reduction of its payload.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register and bit counter.
// Latency: load/shift take effect on the next CLK edge; o_bit0 is the bit
// currently on the line while in DATA, o_bit1 the one after the next shift.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_bit0,
  output logic                  o_bit1,
  output logic                  o_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift_reg;
  logic [CNT_W-1:0]      r_bit_cnt;

  // Load clears the counter; each shift advances to the next payload bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
    end else if (i_load) begin
      r_shift_reg <= i_data;
      r_bit_cnt   <= '0;
    end else if (i_shift) begin
      r_shift_reg <= r_shift_reg >> 1;
      r_bit_cnt   <= r_bit_cnt + 1'b1;
    end
  end

  assign o_bit0 = r_shift_reg[0];
  assign o_bit1 = r_shift_reg[1];
  assign o_done = (r_bit_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_top.sv
// uart_tx_top: UART transmitter, start + DATA_WIDTH bits LSB first + optional parity + stop.
// Latency: byte accepted in cycle n drives the start bit in cycle n+1; one bit per CLK.
// Backpressure: DATA_VALID while busy is dropped unless UART_TX_HOLD_BUF_EN adds a one-entry holding buffer.
module uart_tx_top
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  HOLD_FULL
);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_en;
  logic                  w_load_typ;
  logic                  w_hold_pending;
  logic                  w_shift;
  logic                  w_bit0;
  logic                  w_bit1;
  logic                  w_done;

`ifdef UART_TX_HOLD_BUF_EN
  logic                  r_hold_vld;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_en;
  logic                  r_hold_typ;
  logic                  w_drain;
  logic                  w_capture;

  // A held frame is launched from STOP (back-to-back) or from IDLE if it
  // was captured during the final stop-bit cycle.
  assign w_drain   = r_hold_vld && ((r_state == STOP) || (r_state == IDLE));
  assign w_capture = DATA_VALID && (r_busy || w_drain) && (!r_hold_vld || w_drain);

  assign w_load      = w_drain || ((r_state == IDLE) && DATA_VALID);
  assign w_load_data = w_drain ? r_hold_data : P_DATA;
  assign w_load_en   = w_drain ? r_hold_en   : PAR_EN;
  assign w_load_typ  = w_drain ? r_hold_typ  : PAR_TYP;
  assign w_hold_pending = r_hold_vld;
  assign HOLD_FULL      = r_hold_vld;

  // Holding buffer: capture while busy, free again when its frame is loaded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_en   <= 1'b0;
      r_hold_typ  <= 1'b0;
    end else if (w_capture) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= P_DATA;
      r_hold_en   <= PAR_EN;
      r_hold_typ  <= PAR_TYP;
    end else if (w_drain) begin
      r_hold_vld  <= 1'b0;
    end
  end
`else
  assign w_load         = (r_state == IDLE) && DATA_VALID;
  assign w_load_data    = P_DATA;
  assign w_load_en      = PAR_EN;
  assign w_load_typ     = PAR_TYP;
  assign w_hold_pending = 1'b0;
  assign HOLD_FULL      = 1'b0;
`endif

  // Payload only advances between data bits; the first bit is shown straight from START.
  assign w_shift = (r_state == DATA) && !w_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_shift (w_shift),
    .o_bit0  (w_bit0),
    .o_bit1  (w_bit1),
    .o_done  (w_done)
  );

  // Latch per-frame parity settings so mid-frame input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= w_load_en;
      r_par_bit <= parity_bit(^w_load_data, w_load_typ);
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: frame sequencing.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_load) w_state_nxt = START;
      START:   w_state_nxt = DATA;
      DATA:    if (w_done) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY:  w_state_nxt = STOP;
      STOP:    w_state_nxt = w_hold_pending ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: line level and busy for the state about to be entered,
  // so the registered outputs line up with the state they describe.
  always_comb begin
    w_tx_nxt   = IDLE_LEVEL;
    w_busy_nxt = 1'b1;
    unique case (w_state_nxt)
      IDLE: begin
        w_tx_nxt   = IDLE_LEVEL;
        w_busy_nxt = 1'b0;
      end
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = (r_state == START) ? w_bit0 : w_bit1;
      PARITY:  w_tx_nxt = r_par_bit;
      STOP:    w_tx_nxt = STOP_BIT;
      default: begin
        w_tx_nxt   = IDLE_LEVEL;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered serial line and busy flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx   <= IDLE_LEVEL;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_top.sv
// Testbench for uart_tx_top: table of directed frames plus hand-written
// sequences for mid-frame DATA_VALID and mid-frame reset.
// Builds with or without UART_TX_HOLD_BUF_EN.
module tb_uart_tx_top;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  logic       HOLD_FULL;

`ifdef UART_TX_HOLD_BUF_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_top #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .HOLD_FULL  (HOLD_FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  data;
    logic        en;
    logic        typ;
    int          len;
    logic [10:0] bits;   // bits[i] = TX_OUT in frame cycle i
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one accepted byte at the current negedge; inputs are scrambled
  // afterwards to show they are latched at acceptance.
  task automatic send(input logic [7:0] d, input logic en, input logic typ);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA = ~d; PAR_EN = ~en; PAR_TYP = ~typ;
  endtask

  task automatic expect_frame(input string name, input logic [10:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s tx[%0d]", name, i), TX_OUT, bits[i]);
      check($sformatf("%s busy[%0d]", name, i), Busy, 1);
      @(negedge CLK);
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s idle tx", name), TX_OUT, 1);
      check($sformatf("%s idle busy", name), Busy, 0);
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'hA5, en: 1'b1, typ: 1'b0, len: 11, bits: 11'b10101001010};
    vecs[1] = '{data: 8'h3C, en: 1'b0, typ: 1'b0, len: 10, bits: 11'b01001111000};
    vecs[2] = '{data: 8'hFF, en: 1'b1, typ: 1'b1, len: 11, bits: 11'b11111111110};
    vecs[3] = '{data: 8'h00, en: 1'b1, typ: 1'b0, len: 11, bits: 11'b10000000000};
    vecs[4] = '{data: 8'h01, en: 1'b1, typ: 1'b1, len: 11, bits: 11'b10000000010};
    vecs[5] = '{data: 8'h80, en: 1'b0, typ: 1'b1, len: 10, bits: 11'b01100000000};
    vecs[6] = '{data: 8'h5A, en: 1'b1, typ: 1'b1, len: 11, bits: 11'b11010110100};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset tx", TX_OUT, 1);
    check("reset busy", Busy, 0);
    check("reset hold", HOLD_FULL, 0);
    RST = 1'b0;
    idle_cycles("post reset", 2);

    // Table frames, each sent in the single idle cycle after the previous stop
    for (int v = 0; v < 7; v++) begin
      check($sformatf("vec%0d pre tx", v), TX_OUT, 1);
      check($sformatf("vec%0d pre busy", v), Busy, 0);
      send(vecs[v].data, vecs[v].en, vecs[v].typ);
      expect_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].len);
    end
    idle_cycles("after table", 2);

    // DATA_VALID with 0x55 pulsed during the DATA phase of an A5 frame
    send(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("busyDV tx[%0d]", i), TX_OUT, vecs[0].bits[i]);
      check($sformatf("busyDV busy[%0d]", i), Busy, 1);
      check($sformatf("busyDV hold[%0d]", i), HOLD_FULL, (HOLD && i >= 4) ? 1 : 0);
      if (i == 3) begin
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      end
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end
`ifdef UART_TX_HOLD_BUF_EN
    check("chained hold cleared", HOLD_FULL, 0);
    expect_frame("chained55", 11'b01010101010, 10);
    idle_cycles("after chain", 2);
`else
    idle_cycles("dropped55", 3);
`endif

    // Reset asserted during data bit 4 (frame cycle 5)
    send(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst frame tx[%0d]", i), TX_OUT, vecs[0].bits[i]);
      if (i == 2) begin
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      end
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end
    check("rst frame tx[5]", TX_OUT, vecs[0].bits[5]);
    check("rst frame hold", HOLD_FULL, HOLD);
    RST = 1'b1;
    #1;
    check("midframe rst tx", TX_OUT, 1);
    check("midframe rst busy", Busy, 0);
    check("midframe rst hold", HOLD_FULL, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles("after midframe rst", 3);
    send(8'h3C, 1'b0, 1'b0);
    expect_frame("post rst 3C", vecs[1].bits, 10);
    idle_cycles("end", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
